// File: rtl/fetch_pkg.sv
// Shared constants and the timing legality check for the fetch sequencer.
package fetch_pkg;

  localparam int ADDR_W_DEF     = 12;
  localparam int INST_W_DEF     = 16;
  localparam int CLK_DIV_DEF    = 16;
  localparam int MEM_LAT_DEF    = 1;
  localparam int STEP_CNT_W_DEF = 32;

  localparam logic [15:0] NOP = 16'h0000;

  // Capture must land strictly before the last phase so decode is settled at step time.
  function automatic bit timing_ok(input int clk_div, input int mem_lat);
    return (mem_lat >= 1) && (clk_div >= mem_lat + 2);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// IRAM read port between the fetch sequencer (master) and instruction memory (slave).
interface fetch_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int INST_W = 16
);
  logic [ADDR_W-1:0] iram_addr;
  logic [INST_W-1:0] iram_dout;

  modport master (output iram_addr, input iram_dout);
  modport slave  (input iram_addr, output iram_dout);
endinterface

// File: rtl/step_strobe_gen.sv
// Free-running phase counter 0..CLK_DIV-1 with last-phase and capture-phase flags.
module step_strobe_gen #(
  parameter int CLK_DIV = 16,
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  output logic cnt_last,
  output logic cnt_capture
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(CLK_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign cnt_last    = (cnt == CNT_W'(CLK_DIV - 1));
  assign cnt_capture = (cnt == CNT_W'(MEM_LAT));

endmodule

// File: rtl/fetch_sequencer.sv
// Single-clock instruction fetch: program counter, instruction register and step strobe.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                INST_W     = INST_W_DEF,
  parameter int                CLK_DIV    = CLK_DIV_DEF,
  parameter int                MEM_LAT    = MEM_LAT_DEF,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                STEP_CNT_W = STEP_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  jmp,
  input  logic [ADDR_W-1:0]     jmp_addr,
  input  logic                  no_inc,
  fetch_sequencer_if.master     iram,
  output logic [INST_W-1:0]     instruction,
  output logic                  inst_valid,
  output logic                  step_en,
  output logic [STEP_CNT_W-1:0] step_count
);

  generate
    if (!timing_ok(CLK_DIV, MEM_LAT)) begin : g_bad_timing
      $error("fetch_sequencer: CLK_DIV must be >= MEM_LAT+2 and MEM_LAT >= 1");
    end
  endgenerate

  logic              cnt_last;
  logic              cnt_capture;
  logic [ADDR_W-1:0] pc;

  step_strobe_gen #(
    .CLK_DIV (CLK_DIV),
    .MEM_LAT (MEM_LAT)
  ) u_strobe (
    .clk         (clk),
    .reset       (reset),
    .cnt_last    (cnt_last),
    .cnt_capture (cnt_capture)
  );

  assign iram.iram_addr = pc;
  assign step_en        = cnt_last && !stall && inst_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_ADDR;
      instruction <= INST_W'(NOP);
      inst_valid  <= 1'b0;
      step_count  <= '0;
    end else begin
      if (step_en) begin
        if (jmp) begin
          pc <= jmp_addr;
        end else if (!no_inc) begin
          pc <= pc + ADDR_W'(1);
        end
        if (step_count != '1) begin
          step_count <= step_count + STEP_CNT_W'(1);
        end
      end
      // Capture and step phases never coincide, so the fetched word always matches pc.
      if (cnt_capture) begin
        instruction <= iram.iram_dout;
        inst_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench: two fetch_sequencer configurations checked every cycle against a timeline model.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: default timing. Instance B: CLK_DIV=5, MEM_LAT=3, 4-bit counter, PC near top.
  logic        rst_a, stall_a, jmp_a, no_inc_a;
  logic [11:0] jaddr_a;
  logic [15:0] inst_a;
  logic        valid_a, step_a;
  logic [31:0] sc_a;

  logic        rst_b, stall_b, jmp_b, no_inc_b;
  logic [11:0] jaddr_b;
  logic [15:0] inst_b;
  logic        valid_b, step_b;
  logic [3:0]  sc_b;

  fetch_sequencer_if #(.ADDR_W(12), .INST_W(16)) iram_a ();
  fetch_sequencer_if #(.ADDR_W(12), .INST_W(16)) iram_b ();

  fetch_sequencer dut_a (
    .clk (clk), .reset (rst_a), .stall (stall_a), .jmp (jmp_a), .jmp_addr (jaddr_a),
    .no_inc (no_inc_a), .iram (iram_a), .instruction (inst_a), .inst_valid (valid_a),
    .step_en (step_a), .step_count (sc_a)
  );

  fetch_sequencer #(
    .CLK_DIV (5), .MEM_LAT (3), .RESET_ADDR (12'hFFD), .STEP_CNT_W (4)
  ) dut_b (
    .clk (clk), .reset (rst_b), .stall (stall_b), .jmp (jmp_b), .jmp_addr (jaddr_b),
    .no_inc (no_inc_b), .iram (iram_b), .instruction (inst_b), .inst_valid (valid_b),
    .step_en (step_b), .step_count (sc_b)
  );

  function automatic logic [15:0] mem_fn(input logic [11:0] a);
    return {4'h0, a} + 16'h0100;
  endfunction

  // IRAM models with 1 and 3 cycles of read latency.
  logic [15:0] pipe_a;
  logic [15:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_a    <= mem_fn(iram_a.iram_addr);
    pipe_b[0] <= mem_fn(iram_b.iram_addr);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign iram_a.iram_dout = pipe_a;
  assign iram_b.iram_dout = pipe_b[2];

  function automatic int cd(input int s);  return (s == 0) ? 16 : 5; endfunction
  function automatic int ml(input int s);  return (s == 0) ? 1 : 3;  endfunction
  function automatic longint unsigned sc_max(input int s);
    return (s == 0) ? 64'hFFFF_FFFF : 64'hF;
  endfunction
  function automatic logic [11:0] ra(input int s); return (s == 0) ? 12'h000 : 12'hFFD; endfunction

  // Model: elapsed cycles since reset; phase is that count modulo the step period.
  int unsigned      t_m   [2];
  logic [11:0]      pc_m  [2];
  logic [15:0]      inst_m[2];
  bit               val_m [2];
  longint unsigned  sc_m  [2];
  bit               known [2];

  bit          rnd[2];
  bit          k_rst[2], k_stall[2], k_jmp[2], k_noinc[2];
  logic [11:0] k_addr[2];
  bit          c_rst[2], c_stall[2], c_jmp[2], c_noinc[2];
  logic [11:0] c_addr[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic drive(input int s);
    if (rnd[s]) begin
      c_rst[s]   = ($urandom_range(0, 199) == 0);
      c_stall[s] = ($urandom_range(0, 7) == 0);
      c_jmp[s]   = ($urandom_range(0, 3) == 0);
      c_noinc[s] = ($urandom_range(0, 3) == 0);
      c_addr[s]  = 12'($urandom);
    end else begin
      c_rst[s]   = k_rst[s];
      c_stall[s] = k_stall[s];
      c_jmp[s]   = k_jmp[s];
      c_noinc[s] = k_noinc[s];
      c_addr[s]  = k_addr[s];
    end
    if (s == 0) begin
      rst_a = c_rst[0]; stall_a = c_stall[0]; jmp_a = c_jmp[0];
      no_inc_a = c_noinc[0]; jaddr_a = c_addr[0];
    end else begin
      rst_b = c_rst[1]; stall_b = c_stall[1]; jmp_b = c_jmp[1];
      no_inc_b = c_noinc[1]; jaddr_b = c_addr[1];
    end
  endtask

  function automatic bit exp_step(input int s);
    return ((t_m[s] % cd(s)) == cd(s) - 1) && !c_stall[s] && val_m[s];
  endfunction

  task automatic check(input int s);
    string p;
    p = (s == 0) ? "a" : "b";
    if (s == 0) begin
      chk({p, ".step_en"},     64'(step_a),           64'(exp_step(0)));
      chk({p, ".iram_addr"},   64'(iram_a.iram_addr), 64'(pc_m[0]));
      chk({p, ".instruction"}, 64'(inst_a),           64'(inst_m[0]));
      chk({p, ".inst_valid"},  64'(valid_a),          64'(val_m[0]));
      chk({p, ".step_count"},  64'(sc_a),             sc_m[0]);
    end else begin
      chk({p, ".step_en"},     64'(step_b),           64'(exp_step(1)));
      chk({p, ".iram_addr"},   64'(iram_b.iram_addr), 64'(pc_m[1]));
      chk({p, ".instruction"}, 64'(inst_b),           64'(inst_m[1]));
      chk({p, ".inst_valid"},  64'(valid_b),          64'(val_m[1]));
      chk({p, ".step_count"},  64'(sc_b),             sc_m[1]);
    end
  endtask

  task automatic update(input int s);
    bit          st;
    logic [11:0] old_pc;
    st     = exp_step(s);
    old_pc = pc_m[s];
    if (c_rst[s]) begin
      t_m[s] = 0; pc_m[s] = ra(s); inst_m[s] = 16'h0000; val_m[s] = 1'b0;
      sc_m[s] = 0; known[s] = 1'b1;
    end else begin
      if (st) begin
        if (c_jmp[s])        pc_m[s] = c_addr[s];
        else if (!c_noinc[s]) pc_m[s] = old_pc + 12'd1;
        if (sc_m[s] < sc_max(s)) sc_m[s] = sc_m[s] + 1;
      end
      if ((t_m[s] % cd(s)) == ml(s)) begin
        inst_m[s] = mem_fn(old_pc);
        val_m[s]  = 1'b1;
      end
      t_m[s] = t_m[s] + 1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0);
      drive(1);
      @(negedge clk);
      if (known[0]) check(0);
      if (known[1]) check(1);
      @(posedge clk);
      update(0);
      update(1);
      #1;
    end
  endtask

  task automatic knobs_a(input bit r, input bit st, input bit j, input bit n, input logic [11:0] a);
    k_rst[0] = r; k_stall[0] = st; k_jmp[0] = j; k_noinc[0] = n; k_addr[0] = a;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rnd[s] = 1'b0; known[s] = 1'b0;
      k_rst[s] = 1'b1; k_stall[s] = 1'b0; k_jmp[s] = 1'b0; k_noinc[s] = 1'b0; k_addr[s] = '0;
      t_m[s] = 0; pc_m[s] = '0; inst_m[s] = '0; val_m[s] = 1'b0; sc_m[s] = 0;
    end
    run(3);
    k_rst[1] = 1'b0;
    rnd[1]   = 1'b1;
    knobs_a(0, 0, 0, 0, 12'h000);

    chk("reset_addr",  64'(iram_a.iram_addr), 64'h0);
    chk("reset_valid", 64'(valid_a),          64'h0);
    run(2);
    chk("first_inst",  64'(inst_a),           64'h0100);
    run(14);
    chk("first_step_addr",  64'(iram_a.iram_addr), 64'h1);
    chk("first_step_count", 64'(sc_a),             64'h1);

    run(80);
    chk("seq_addr",  64'(iram_a.iram_addr), 64'h6);
    chk("seq_count", 64'(sc_a),             64'h6);

    knobs_a(0, 0, 1, 1, 12'h3A0);
    run(16);
    knobs_a(0, 0, 0, 0, 12'h000);
    chk("jmp_priority", 64'(iram_a.iram_addr), 64'h3A0);
    run(2);
    chk("jmp_inst", 64'(inst_a), 64'h04A0);
    run(14);

    knobs_a(0, 0, 1, 0, 12'hFFF);
    run(16);
    knobs_a(0, 0, 0, 0, 12'h000);
    chk("at_top", 64'(iram_a.iram_addr), 64'hFFF);
    run(16);
    chk("wrap_addr", 64'(iram_a.iram_addr), 64'h0);

    knobs_a(0, 1, 0, 0, 12'h000);
    run(48);
    knobs_a(0, 0, 0, 0, 12'h000);
    chk("stall_addr",  64'(iram_a.iram_addr), 64'h0);
    chk("stall_count", 64'(sc_a),             64'd10);

    run(9);
    knobs_a(1, 0, 0, 0, 12'h000);
    run(1);
    knobs_a(0, 0, 0, 0, 12'h000);
    chk("midrst_valid", 64'(valid_a),          64'h0);
    chk("midrst_addr",  64'(iram_a.iram_addr), 64'h0);
    chk("midrst_count", 64'(sc_a),             64'h0);
    run(15);
    chk("midrst_no_early_step", 64'(sc_a), 64'h0);
    run(1);
    chk("midrst_first_step", 64'(sc_a), 64'h1);

    rnd[0] = 1'b1;
    run(1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
